// File: rtl/uart_tx_slave_if.sv
// Single-beat data-bus port of the UART transmitter: request from the core,
// registered response from the slave.
interface uart_tx_slave_if;
  logic        ss;
  logic        bstart;
  logic        bwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  tsize;
  logic [31:0] rdata;
  logic        bdone;
  logic        berror;

  modport master (
    output ss, bstart, bwrite, addr, wdata, tsize,
    input  rdata, bdone, berror
  );

  modport slave (
    input  ss, bstart, bwrite, addr, wdata, tsize,
    output rdata, bdone, berror
  );
endinterface

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/BAUD registers, TX FIFO,
// and a bit-period down-counter driving the serial FSM.
//
// state   | meaning
// S_IDLE  | line idle high, waiting for a byte in the FIFO
// S_START | start bit (low) for one bit period
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (high); pops the next byte for gapless frames
module uart_tx_slave #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_slave_if.slave bus,
  output logic          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_d;
  logic [15:0]   timer, timer_d;
  logic [15:0]   baud;
  logic [7:0]    shift, shift_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic          tx_d;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [4:0]    count_ext;
  logic          full, empty;

  logic          acc, push;
  logic [1:0]    reg_sel;
  logic [31:0]   status;
  logic [31:0]   rdata_q;
  logic          bdone_q, berror_q;
  logic          unused;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign count_ext = 5'(count);
  assign acc       = bus.ss && bus.bstart;
  assign reg_sel   = bus.addr[3:2];
  // Push is judged on the pre-pop count, so a full FIFO rejects even on a pop cycle.
  assign push      = acc && bus.bwrite && (reg_sel == 2'd0) && !full;
  assign status    = {24'b0, count_ext[3:0], 1'b0, empty, full, state != S_IDLE};

  assign bus.rdata  = rdata_q;
  assign bus.bdone  = bdone_q;
  assign bus.berror = berror_q;

  assign unused = ^{bus.tsize, bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    pop       = 1'b0;
    tx_d      = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          timer_d = baud;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (timer == 16'd0) begin
          timer_d   = baud;
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      S_DATA: begin
        tx_d = shift[0];
        if (timer == 16'd0) begin
          timer_d   = baud;
          shift_d   = {1'b0, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (timer == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            timer_d = baud;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      bdone_q  <= 1'b0;
      berror_q <= 1'b0;
      baud     <= DEFAULT_DIV;
    end else begin
      bdone_q  <= acc;
      berror_q <= 1'b0;
      rdata_q  <= '0;
      if (acc) begin
        case (reg_sel)
          2'd0: if (bus.bwrite && full) berror_q <= 1'b1;
          2'd1: if (!bus.bwrite) rdata_q <= status;
          2'd2: begin
            if (bus.bwrite) baud <= bus.wdata[15:0];
            else            rdata_q <= {16'b0, baud};
          end
          default: berror_q <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Self-checking bench for uart_tx_slave: bus responses and serial frames are
// checked against scoreboards filled as stimulus is driven.
module tb_uart_tx_slave;
  localparam int          FIFO_DEPTH  = 8;
  localparam logic [15:0] DEFAULT_DIV = 16'd867;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  uart_tx_slave_if bus ();

  uart_tx_slave #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  logic [32:0] bus_q [$];
  logic [7:0]  tx_q [$];
  int          n_cmp    = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          div_cur  = int'(DEFAULT_DIV);
  logic        acc_prev = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acc_prev <= rst_n && bus.ss && bus.bstart;
  end

  // bus response monitor: bdone must follow each accepted bstart by one cycle
  always @(negedge clk) begin
    logic [32:0] e;
    if (acc_prev || bus.bdone) begin
      n_cmp++;
      if (bus.bdone !== acc_prev) begin
        n_fail++;
        $display("FAIL bdone_latency: bdone=%b required=%b at %0t", bus.bdone, acc_prev, $time);
        if (acc_prev && bus_q.size() > 0) void'(bus_q.pop_front());
      end else if (bus_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_scoreboard: bdone with no expected response at %0t", $time);
      end else begin
        e = bus_q.pop_front();
        n_cmp++;
        if ({bus.rdata, bus.berror} !== e) begin
          n_fail++;
          $display("FAIL bus_response: rdata=%h berror=%b required rdata=%h berror=%b at %0t",
                   bus.rdata, bus.berror, e[32:1], e[0], $time);
        end
      end
    end
  end

  // serial monitor: decodes 8N1 frames at the current divisor
  logic [7:0] mon_b, mon_exp;
  logic       mon_ok, mon_abort;
  int         mon_p;
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      mon_p = div_cur + 1; mon_ok = 1'b1; mon_abort = 1'b0; mon_b = '0;
      for (int c = 1; c < mon_p && !mon_abort; c++) begin
        @(negedge clk);
        if (!rst_n) mon_abort = 1'b1; else if (tx !== 1'b0) mon_ok = 1'b0;
      end
      for (int i = 0; i < 8 && !mon_abort; i++)
        for (int c = 0; c < mon_p && !mon_abort; c++) begin
          @(negedge clk);
          if (!rst_n) mon_abort = 1'b1;
          else if (c == 0) mon_b[i] = tx;
          else if (tx !== mon_b[i]) mon_ok = 1'b0;
        end
      for (int c = 0; c < mon_p && !mon_abort; c++) begin
        @(negedge clk);
        if (!rst_n) mon_abort = 1'b1; else if (tx !== 1'b1) mon_ok = 1'b0;
      end
      if (!mon_abort) begin
        n_cmp++;
        if (!mon_ok) begin
          n_fail++;
          $display("FAIL tx_framing: byte %h bit timing or start/stop level wrong at %0t", mon_b, $time);
        end
        n_cmp++;
        if (tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: unexpected frame %h, none required at %0t", mon_b, $time);
        end else begin
          mon_exp = tx_q.pop_front();
          if (mon_b !== mon_exp) begin
            n_fail++;
            $display("FAIL tx_byte: got %h required %h at %0t", mon_b, mon_exp, $time);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_idle();
    bus.ss = 1'b0; bus.bstart = 1'b0; bus.bwrite = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.tsize = 2'd0;
  endtask

  task automatic bus_start(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err);
    bus.ss = 1'b1; bus.bstart = 1'b1; bus.bwrite = wr;
    bus.addr = a; bus.wdata = d; bus.tsize = 2'd2;
    bus_q.push_back({exp_rd, exp_err});
    tick(1);
  endtask

  task automatic write_baud(input int v);
    bus_start(1'b1, 32'h8, 32'(v), 32'h0, 1'b0);
    bus_idle();
    tick(1);
    div_cur = v;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (tx_q.size() != 0 && k < budget) begin tick(1); k++; end
    tick(2);
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", tx_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_idle();
    tick(2);
    n_cmp++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx: tx=%b required 1", tx);
    end
    n_cmp++;
    if ({bus.bdone, bus.berror, bus.rdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_bus: bdone=%b berror=%b rdata=%h required 0", bus.bdone, bus.berror, bus.rdata);
    end
    rst_n = 1'b1;
    tick(1);
    bus_start(1'b0, 32'h4, 32'h0, 32'h4, 1'b0);
    bus_idle();
    n_cmp++;
    if (bus.bdone !== 1'b1 || bus.rdata !== 32'h4) begin
      n_fail++; $display("FAIL reset_status: bdone=%b rdata=%h required 1/00000004", bus.bdone, bus.rdata);
    end
    tick(1);
    n_cmp++;
    if (bus.bdone !== 1'b0 || bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL bdone_pulse: bdone=%b rdata=%h required 0/00000000", bus.bdone, bus.rdata);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] exp;
    write_baud(3);
    bus_start(1'b1, 32'h0, 32'hA5, 32'h0, 1'b0);
    tx_q.push_back(8'hA5);
    for (int k = 1; k <= 42; k++) begin
      exp = (k == 1) ? 32'h10 : (k <= 41) ? 32'h5 : 32'h4;
      bus_start(1'b0, 32'h4, 32'h0, exp, 1'b0);
      if (k == 1) begin
        n_cmp++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_before_start: tx=%b required 1", tx); end
      end
      if (k == 2) begin
        n_cmp++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL tx_start_edge: tx=%b required 0", tx); end
      end
    end
    bus_idle();
    wait_drain(100);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bs [3];
    logic [29:0] exp_seq, got;
    bs = '{8'h00, 8'hFF, 8'h55};
    write_baud(0);
    for (int f = 0; f < 3; f++) begin
      bus_start(1'b1, 32'h0, {24'h0, bs[f]}, 32'h0, 1'b0);
      tx_q.push_back(bs[f]);
    end
    bus_idle();
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 10; j++)
        exp_seq[f*10+j] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bs[f][j-1];
    got[0] = tx;
    for (int t = 1; t < 30; t++) begin tick(1); got[t] = tx; end
    n_cmp++;
    if (got !== exp_seq) begin
      n_fail++; $display("FAIL back_to_back_stream: got %b required %b", got, exp_seq);
    end
    tick(3);
    bus_start(1'b0, 32'h4, 32'h0, 32'h4, 1'b0);
    bus_idle();
    wait_drain(50);
  endtask

  task automatic test_fifo_full();
    int          e0;
    logic [7:0]  d;
    write_baud(3);
    bus_start(1'b1, 32'h0, 32'h10, 32'h0, 1'b0);
    tx_q.push_back(8'h10);
    e0 = cyc;
    for (int i = 1; i <= 9; i++) begin
      d = 8'h20 + 8'(i);
      bus_start(1'b1, 32'h0, {24'h0, d}, 32'h0, i == 9);
      if (i != 9) tx_q.push_back(d);
    end
    bus_start(1'b0, 32'h4, 32'h0, 32'h83, 1'b0);
    bus_idle();
    // land a write on the exact edge where the running frame pops the next byte
    wait_until(e0 + 40);
    bus_start(1'b1, 32'h0, 32'hEE, 32'h0, 1'b1);
    bus_start(1'b0, 32'h4, 32'h0, 32'h71, 1'b0);
    bus_idle();
    wait_drain(600);
  endtask

  task automatic test_regs();
    bus_start(1'b0, 32'hC, 32'h0, 32'h0, 1'b1);
    bus_start(1'b1, 32'hC, 32'hFFFF_FFFF, 32'h0, 1'b1);
    bus_start(1'b1, 32'h8, 32'h1234_5678, 32'h0, 1'b0);
    bus_start(1'b0, 32'h8, 32'h0, 32'h5678, 1'b0);
    bus_start(1'b0, 32'hABCD_0008, 32'h0, 32'h5678, 1'b0);
    bus_start(1'b1, 32'h4, 32'hFF, 32'h0, 1'b0);
    bus_start(1'b0, 32'h4, 32'h0, 32'h4, 1'b0);
    bus_start(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    bus_idle();
    tick(2);
    write_baud(3);
  endtask

  task automatic test_reset_mid();
    bus_start(1'b1, 32'h0, 32'h3C, 32'h0, 1'b0);
    bus_start(1'b1, 32'h0, 32'hC3, 32'h0, 1'b0);
    bus_idle();
    tick(9);
    n_cmp++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_frame_bit: tx=%b required 0", tx); end
    rst_n = 1'b0;
    tick(1);
    n_cmp++;
    if (tx !== 1'b1 || bus.bdone !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_tx: tx=%b bdone=%b required 1/0", tx, bus.bdone);
    end
    rst_n = 1'b1;
    div_cur = int'(DEFAULT_DIV);
    tick(1);
    bus_start(1'b0, 32'h4, 32'h0, 32'h4, 1'b0);
    bus_start(1'b0, 32'h8, 32'h0, {16'h0, DEFAULT_DIV}, 1'b0);
    bus_idle();
    tick(20);
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_mid_idle: tx=%b required 1", tx); end
  endtask

  initial begin
    bus_idle();
    tick(1);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_regs();
    test_reset_mid();
    tick(2);
    n_cmp++;
    if (bus_q.size() != 0) begin
      n_fail++; $display("FAIL bus_outstanding: %0d responses missing, required 0", bus_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
